// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier result path: default widths and the
// accumulator state encoding (also used by the multiplier bench).
package mul_pkg;

  localparam int unsigned PROD_W_DEF = 128;
  localparam int unsigned LEN_W_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating two's-complement adder with overflow flag.
module sat_add #(
  parameter int unsigned PROD_W = 128
) (
  input  logic [PROD_W-1:0] i_a,
  input  logic [PROD_W-1:0] i_b,
  output logic [PROD_W-1:0] o_sum,
  output logic              o_ovf
);

  logic [PROD_W-1:0] w_raw;
  logic [PROD_W-1:0] w_max;
  logic [PROD_W-1:0] w_min;

  assign w_raw = i_a + i_b;
  assign w_max = {1'b0, {(PROD_W-1){1'b1}}};
  assign w_min = {1'b1, {(PROD_W-1){1'b0}}};

  // Overflow only when both operands share a sign the result does not;
  // clamp toward the operands' sign.
  always_comb begin
    o_ovf = (i_a[PROD_W-1] == i_b[PROD_W-1]) && (w_raw[PROD_W-1] != i_a[PROD_W-1]);
    o_sum = w_raw;
    if (o_ovf) begin
      o_sum = i_a[PROD_W-1] ? w_min : w_max;
    end
  end

endmodule

// File: rtl/mul_result_acc.sv
// Batch accumulator for multiplier products: sums `len` products with
// saturation and presents the result through a single-entry output register.
module mul_result_acc
  import mul_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              stb,
  input  logic [PROD_W-1:0] din,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [PROD_W-1:0] dout,
  output logic              out_sat,
  output logic              busy,
  output logic              ovr,
  output logic              drop
);

  acc_state_t        r_state;
  logic [PROD_W-1:0] r_acc;
  logic [LEN_W-1:0]  r_rem;
  logic              r_sat;
  logic              r_out_vld;
  logic [PROD_W-1:0] r_dout;
  logic              r_out_sat;
  logic              r_ovr;
  logic              r_drop;

  logic [PROD_W-1:0] w_sum;
  logic              w_ovf;
  logic              w_last;
  logic              w_load_ok;
  logic              w_restart;

  sat_add #(
    .PROD_W (PROD_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (din),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  assign w_last    = (r_state == ACC) && stb && (r_rem == LEN_W'(1));
  assign w_load_ok = !r_out_vld || out_rdy;
  assign w_restart = start && (len != '0);

  // Batch FSM plus output register; completion and restart share one edge
  // so back-to-back batches run without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_rem     <= '0;
      r_sat     <= 1'b0;
      r_out_vld <= 1'b0;
      r_dout    <= '0;
      r_out_sat <= 1'b0;
      r_ovr     <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      if (w_last) begin
        if (w_load_ok) begin
          r_out_vld <= 1'b1;
          r_dout    <= w_sum;
          r_out_sat <= r_sat | w_ovf;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_out_vld && out_rdy) begin
        r_out_vld <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (stb) begin
            r_drop <= 1'b1;
          end
          if (w_restart) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_rem   <= len;
            r_sat   <= 1'b0;
          end
        end
        ACC: begin
          if (stb) begin
            if (r_rem == LEN_W'(1)) begin
              r_acc <= '0;
              r_sat <= 1'b0;
              if (w_restart) begin
                r_rem <= len;
              end else begin
                r_state <= IDLE;
                r_rem   <= '0;
              end
            end else begin
              r_acc <= w_sum;
              r_rem <= r_rem - LEN_W'(1);
              r_sat <= r_sat | w_ovf;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_vld = r_out_vld;
  assign dout    = r_dout;
  assign out_sat = r_out_sat;
  assign busy    = (r_state == ACC);
  assign ovr     = r_ovr;
  assign drop    = r_drop;

endmodule
